// File: rtl/uart_line_receiver.sv
// Line assembler fed from a buffered UART receive FIFO over a four-phase
// handshake; collects characters until LF and holds the line for a consumer.
module uart_line_receiver #(
  parameter int ADDR_BITS = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_empty,
  output logic                 o_read_req,
  input  logic                 i_read_ack,
  input  logic [10:0]          i_data_in,
  output logic                 o_line_ready,
  output logic [ADDR_BITS:0]   o_line_length,
  output logic                 o_line_error,
  output logic                 o_line_overflow,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [7:0]           o_rd_data,
  input  logic                 i_line_release
);

  // state     | meaning
  // FETCH     | idle, waiting for FIFO data with readAck low
  // WAIT_ACK  | readReq high, waiting for readAck
  // WAIT_DROP | word taken, waiting for readAck to fall
  // READY     | complete line held for the consumer
  typedef enum logic [1:0] {FETCH, WAIT_ACK, WAIT_DROP, READY} state_t;

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS + 1)'(DEPTH);

  state_t               r_state;
  logic [7:0]           r_mem [DEPTH];
  logic [ADDR_BITS:0]   r_count;
  logic                 r_term;
  logic                 r_read_req;
  logic                 r_line_ready;
  logic                 r_line_error;
  logic                 r_line_overflow;
  logic [7:0]           r_rd_data;

  logic [7:0] w_char;
  logic       w_flag;
  logic       w_is_lf;
  logic       w_is_cr;
  logic       w_capture;
  logic       w_store;
  logic       w_wr_en;

  assign w_char    = i_data_in[7:0];
  assign w_flag    = |i_data_in[10:8];
  assign w_is_lf   = (w_char == 8'h0A);
  assign w_is_cr   = (w_char == 8'h0D);
  assign w_capture = (r_state == WAIT_ACK) && i_read_ack;
  // A flagged CR is kept so the consumer can see what arrived damaged
  assign w_store   = w_capture && !w_is_lf && (!w_is_cr || w_flag);
  assign w_wr_en   = w_store && (r_count < FULL) && !i_rst;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_count[ADDR_BITS-1:0]] <= w_char;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= FETCH;
      r_read_req      <= 1'b0;
      r_line_ready    <= 1'b0;
      r_line_error    <= 1'b0;
      r_line_overflow <= 1'b0;
      r_count         <= '0;
      r_term          <= 1'b0;
      r_rd_data       <= 8'h00;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
      case (r_state)
        FETCH: begin
          // readAck must be low first so a handshake torn by reset is not reused
          if (!i_empty && !i_read_ack) begin
            r_read_req <= 1'b1;
            r_state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (i_read_ack) begin
            r_read_req <= 1'b0;
            r_term     <= w_is_lf;
            r_state    <= WAIT_DROP;
            if (w_flag) r_line_error <= 1'b1;
            if (w_store) begin
              if (r_count < FULL) r_count <= r_count + 1'b1;
              else                r_line_overflow <= 1'b1;
            end
          end
        end
        WAIT_DROP: begin
          if (!i_read_ack) begin
            if (r_term) begin
              r_line_ready <= 1'b1;
              r_state      <= READY;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        READY: begin
          if (i_line_release) begin
            r_line_ready    <= 1'b0;
            r_line_error    <= 1'b0;
            r_line_overflow <= 1'b0;
            r_count         <= '0;
            r_state         <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign o_read_req      = r_read_req;
  assign o_line_ready    = r_line_ready;
  assign o_line_length   = r_count;
  assign o_line_error    = r_line_error;
  assign o_line_overflow = r_line_overflow;
  assign o_rd_data       = r_rd_data;

endmodule

// File: tb/tb_uart_line_receiver.sv
// Self-checking bench for uart_line_receiver: a FIFO-side handshake driver,
// a line model feeding a scoreboard queue, and per-scenario status checks.
module tb_uart_line_receiver;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_empty = 1'b1;
  logic        o_read_req;
  logic        i_read_ack = 1'b0;
  logic [10:0] i_data_in = '0;
  logic        o_line_ready;
  logic [6:0]  o_line_length;
  logic        o_line_error;
  logic        o_line_overflow;
  logic [5:0]  i_rd_addr = '0;
  logic [7:0]  o_rd_data;
  logic        i_line_release = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] sb[$];
  int         m_len;

  uart_line_receiver #(.ADDR_BITS(6)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_empty(i_empty), .o_read_req(o_read_req),
    .i_read_ack(i_read_ack), .i_data_in(i_data_in), .o_line_ready(o_line_ready),
    .o_line_length(o_line_length), .o_line_error(o_line_error),
    .o_line_overflow(o_line_overflow), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .i_line_release(i_line_release)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_len = 0;
  endtask

  // FIFO side of the four-phase handshake; ack held high for 'hold' edges
  task automatic drive_word(input logic [10:0] w, input int hold);
    int t = 0;
    i_empty = 1'b0;
    while (!o_read_req && t < 50) begin tick(); t++; end
    n_checks++;
    if (o_read_req !== 1'b1) $display("FAIL req_timeout: read_req=%b required 1", o_read_req);
    else n_pass++;
    i_read_ack = 1'b1;
    i_data_in  = w;
    for (int k = 0; k < hold; k++) tick();
    if (hold > 1) begin
      n_checks++;
      if (o_read_req !== 1'b0) $display("FAIL req_during_ack: read_req=%b required 0", o_read_req);
      else n_pass++;
    end
    i_read_ack = 1'b0;
    i_empty    = 1'b1;
    i_data_in  = '0;
    tick();
  endtask

  task automatic send(input logic [10:0] w, input int hold);
    logic [7:0] c;
    logic       f;
    c = w[7:0];
    f = |w[10:8];
    if (c != 8'h0A && (c != 8'h0D || f)) begin
      if (m_len < 64) begin sb.push_back(c); m_len++; end
    end
    drive_word(w, hold);
  endtask

  task automatic read_back(input string name);
    int a = 0;
    logic [7:0] exp;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      i_rd_addr = 6'(a);
      tick();
      n_checks++;
      if (o_rd_data !== exp)
        $display("FAIL %s_rd[%0d]: got %h required %h", name, a, o_rd_data, exp);
      else n_pass++;
      a++;
    end
  endtask

  task automatic release_line();
    i_line_release = 1'b1;
    tick();
    i_line_release = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({o_read_req, o_line_ready, o_line_error, o_line_overflow} !== 4'b0000)
      $display("FAIL reset_flags: got %b required 0000",
               {o_read_req, o_line_ready, o_line_error, o_line_overflow});
    else n_pass++;
    n_checks++;
    if (o_line_length !== 7'd0 || o_rd_data !== 8'h00)
      $display("FAIL reset_data: len=%0d rd=%h required 0 00", o_line_length, o_rd_data);
    else n_pass++;
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    model_reset();
    send(11'h041, 1); send(11'h042, 1); send(11'h00D, 1); send(11'h00A, 1);
    n_checks++;
    if (o_line_ready !== 1'b1 || o_line_length !== 7'd2 || o_line_error !== 1'b0)
      $display("FAIL basic_status: ready=%b len=%0d err=%b required 1 2 0",
               o_line_ready, o_line_length, o_line_error);
    else n_pass++;
    read_back("basic");
    release_line();
    n_checks++;
    if (o_line_ready !== 1'b0 || o_line_length !== 7'd0)
      $display("FAIL release_clear: ready=%b len=%0d required 0 0", o_line_ready, o_line_length);
    else n_pass++;
  endtask

  task automatic test_long_ack();
    model_reset();
    send(11'h061, 5); send(11'h062, 5); send(11'h00A, 5);
    n_checks++;
    if (o_line_ready !== 1'b1 || o_line_length !== 7'd2)
      $display("FAIL long_ack_len: ready=%b len=%0d required 1 2", o_line_ready, o_line_length);
    else n_pass++;
    read_back("long_ack");
    release_line();
  endtask

  task automatic test_parity();
    model_reset();
    send(11'h143, 1); send(11'h00A, 1);
    n_checks++;
    if (o_line_error !== 1'b1 || o_line_length !== 7'd1)
      $display("FAIL parity_status: err=%b len=%0d required 1 1", o_line_error, o_line_length);
    else n_pass++;
    read_back("parity");
    release_line();
    n_checks++;
    if (o_line_error !== 1'b0)
      $display("FAIL parity_err_clear: err=%b required 0", o_line_error);
    else n_pass++;
  endtask

  task automatic test_flagged_cr_lf();
    model_reset();
    send(11'h20D, 2); send(11'h044, 1); send(11'h40A, 1);
    n_checks++;
    if (o_line_ready !== 1'b1 || o_line_length !== 7'd2 || o_line_error !== 1'b1)
      $display("FAIL flagged_status: ready=%b len=%0d err=%b required 1 2 1",
               o_line_ready, o_line_length, o_line_error);
    else n_pass++;
    read_back("flagged");
    release_line();
  endtask

  task automatic test_release_ignored();
    model_reset();
    send(11'h031, 1);
    release_line();
    send(11'h032, 1); send(11'h00A, 1);
    n_checks++;
    if (o_line_length !== 7'd2)
      $display("FAIL release_ignored_len: got %0d required 2", o_line_length);
    else n_pass++;
    read_back("rel_ign");
    release_line();
  endtask

  task automatic test_empty_line();
    model_reset();
    send(11'h00A, 1);
    n_checks++;
    if (o_line_ready !== 1'b1 || o_line_length !== 7'd0)
      $display("FAIL empty_line: ready=%b len=%0d required 1 0", o_line_ready, o_line_length);
    else n_pass++;
    release_line();
  endtask

  task automatic test_overflow();
    model_reset();
    for (int i = 0; i < 70; i++) send(11'(8'h21 + i), 1);
    send(11'h00A, 1);
    n_checks++;
    if (o_line_length !== 7'd64 || o_line_overflow !== 1'b1 || o_line_error !== 1'b0)
      $display("FAIL overflow_status: len=%0d ovf=%b err=%b required 64 1 0",
               o_line_length, o_line_overflow, o_line_error);
    else n_pass++;
    read_back("overflow");
    release_line();
    n_checks++;
    if (o_line_overflow !== 1'b0)
      $display("FAIL overflow_clear: ovf=%b required 0", o_line_overflow);
    else n_pass++;
  endtask

  task automatic test_hold_ready();
    logic seen_req;
    model_reset();
    send(11'h148, 1); send(11'h00A, 1);
    i_empty = 1'b0;
    seen_req = 1'b0;
    repeat (10) begin tick(); if (o_read_req) seen_req = 1'b1; end
    n_checks++;
    if (seen_req !== 1'b0 || o_line_length !== 7'd1)
      $display("FAIL ready_hold: req_seen=%b len=%0d required 0 1", seen_req, o_line_length);
    else n_pass++;
    sb.delete();
    release_line();
    model_reset();
    send(11'h05A, 1); send(11'h00A, 1);
    n_checks++;
    if (o_line_length !== 7'd1 || o_line_error !== 1'b0)
      $display("FAIL next_line: len=%0d err=%b required 1 0", o_line_length, o_line_error);
    else n_pass++;
    read_back("next_line");
    release_line();
  endtask

  task automatic test_reset_mid();
    logic seen_req;
    int t = 0;
    model_reset();
    send(11'h031, 1); send(11'h032, 1); send(11'h033, 1);
    i_empty = 1'b0;
    while (!o_read_req && t < 50) begin tick(); t++; end
    i_read_ack = 1'b1;
    i_data_in  = 11'h034;
    tick();
    i_rst = 1'b1;
    tick();
    n_checks++;
    if (o_line_length !== 7'd0 || o_read_req !== 1'b0)
      $display("FAIL mid_reset_state: len=%0d req=%b required 0 0", o_line_length, o_read_req);
    else n_pass++;
    i_rst = 1'b0;
    seen_req = 1'b0;
    repeat (4) begin tick(); if (o_read_req) seen_req = 1'b1; end
    n_checks++;
    if (seen_req !== 1'b0)
      $display("FAIL mid_reset_wait_ack: req_seen=%b required 0", seen_req);
    else n_pass++;
    i_read_ack = 1'b0;
    i_empty    = 1'b1;
    i_data_in  = '0;
    tick();
    model_reset();
    send(11'h058, 1); send(11'h00A, 1);
    n_checks++;
    if (o_line_ready !== 1'b1 || o_line_length !== 7'd1)
      $display("FAIL mid_reset_line: ready=%b len=%0d required 1 1", o_line_ready, o_line_length);
    else n_pass++;
    read_back("mid_reset");
    release_line();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_ack();
    test_parity();
    test_flagged_cr_lf();
    test_release_ignored();
    test_empty_line();
    test_overflow();
    test_hold_ready();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_line_receiver.md
UART_LINE_RECEIVER -- requirements
Module: uart_line_receiver

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 6, line buffer address width (capacity 2**ADDR_BITS characters).
REQ-002 clk  input  1  system clock; all state changes SHALL occur on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 empty  input  1  BufferedUart receive FIFO empty.
REQ-005 readReq  output  1  read request to BufferedUart receive FIFO.
REQ-006 readAck  input  1  FIFO acknowledge; dataIn valid while high.
REQ-007 dataIn  input  11  received word: [7:0] character, [8] parity error, [9] framing error, [10] break.
REQ-008 lineReady  output  1  complete line held in buffer.
REQ-009 lineLength  output  ADDR_BITS+1  stored character count, terminator excluded.
REQ-010 lineError  output  1  at least one word of the line carried a flag bit [10:8].
REQ-011 lineOverflow  output  1  line exceeded capacity; excess characters dropped.
REQ-012 rdAddr  input  ADDR_BITS  buffer read address.
REQ-013 rdData  output  8  buffer contents at rdAddr, registered, 1-cycle latency.
REQ-014 lineRelease  input  1  single-cycle pulse: consumer done with line.

Function
REQ-015 The FSM SHALL have states FETCH, WAIT_ACK, WAIT_DROP, READY.
REQ-016 FETCH: readReq SHALL assert the cycle after empty is low; next state WAIT_ACK.
REQ-017 WAIT_ACK: readReq SHALL stay high until readAck is sampled high; on that edge dataIn SHALL be captured, readReq deasserted, next state WAIT_DROP.
REQ-018 WAIT_DROP: readReq SHALL remain low until readAck is sampled low (four-phase handshake); one word SHALL be consumed per readAck high period regardless of its length.
REQ-019 Captured 0x0D SHALL be discarded (no store, no count) unless a flag bit is set.
REQ-020 Captured 0x0A SHALL terminate the line: lineReady set on the edge after readAck falls, state READY; otherwise return to FETCH.
REQ-021 Any other character SHALL be written at address count and count incremented while count < 2**ADDR_BITS.
REQ-022 At count = 2**ADDR_BITS, further characters SHALL be dropped and lineOverflow set; count SHALL saturate (no wrap).
REQ-023 Any captured word with dataIn[10:8] nonzero SHALL set lineError; its character SHALL still be stored per REQ-021/022, and a flagged 0x0A SHALL still terminate.
REQ-024 READY: readReq SHALL stay low; lineLength, lineError, lineOverflow and buffer contents SHALL be stable.
REQ-025 lineRelease in READY SHALL clear lineReady, lineError, lineOverflow and count on the next edge and return to FETCH; lineRelease in any other state SHALL be ignored.
REQ-026 rdData SHALL reflect buffer[rdAddr] one cycle after rdAddr is presented, in every state; reads beyond lineLength return stale data.
REQ-027 Empty line (0x0A first) SHALL produce lineReady with lineLength 0.

Reset
REQ-028 While rst is high: state FETCH, readReq 0, lineReady 0, lineLength 0, lineError 0, lineOverflow 0, rdData 0; buffer contents not cleared.
REQ-029 rst asserted mid-handshake (WAIT_ACK/WAIT_DROP) SHALL abandon the partial line; after release the block SHALL wait for readAck low before asserting readReq.

Verification
REQ-030 Words 0x41,0x42,0x0D,0x0A with clean flags -> lineReady=1, lineLength=2, rdData 0x41 at addr 0 and 0x42 at addr 1, lineError=0.
REQ-031 readAck held high 5 cycles per word -> each word counted once; readReq low until readAck falls.
REQ-032 Word 0x143 (parity error, 'C') then 0x0A -> lineError=1, lineLength=1, rdData[0]=0x43.
REQ-033 ADDR_BITS=6, 70 characters then 0x0A -> lineLength=64, lineOverflow=1, addr 63 holds character 64.
REQ-034 Line ready, further words in FIFO -> readReq stays 0 until lineRelease pulse; next line starts at addr 0 with flags cleared.
REQ-035 rst pulse after 3 characters, then 0x58,0x0A -> lineLength=1, rdData[0]=0x58.
